mpmc11_wdf_feeder: RTL and testbench

MPMC11_WDF_FEEDER -- requirements
Module: mpmc11_wdf_feeder

---
 rtl/mpmc11_pkg.sv | 12 +
 rtl/mpmc11_wdf_ram.sv | 24 ++
 rtl/mpmc11_wdf_feeder.sv | 107 ++++++++++
 tb/tb_mpmc11_wdf_feeder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mpmc11_pkg.sv
// Shared types and default sizing for the MPMC11 write-data path.
package mpmc11_pkg;

    typedef enum logic {
        BEAT0 = 1'b0,
        BEAT1 = 1'b1
    } beat_e;

    localparam int unsigned MPMC11_DW    = 128;
    localparam int unsigned MPMC11_DEPTH = 4;

endpackage

// File: rtl/mpmc11_wdf_ram.sv
// Beat storage: simple dual-port array, registered write, asynchronous read.
module mpmc11_wdf_ram #(
    parameter int unsigned W     = 144,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mpmc11_wdf_feeder.sv
// Buffers upstream write beats and presents them to the MIG write data FIFO,
// tracking burst phase to drive app_wdf_end and a burst_done pulse.
module mpmc11_wdf_feeder
    import mpmc11_pkg::*;
#(
    parameter int unsigned DW    = MPMC11_DW,
    parameter int unsigned DEPTH = MPMC11_DEPTH,
    parameter int unsigned BPB   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DW-1:0]          s_data,
    input  logic [DW/8-1:0]        s_mask,
    input  logic                   app_wdf_rdy,
    output logic                   app_wdf_wren,
    output logic [DW-1:0]          app_wdf_data,
    output logic [DW/8-1:0]        app_wdf_mask,
    output logic                   app_wdf_end,
    output logic [$clog2(DEPTH):0] level,
    output logic                   burst_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned MW = DW / 8;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_q;
    logic             burst_done_q;
    beat_e            phase_q;
    beat_e            phase_d;
    logic             push;
    logic             pop;
    logic [DW+MW-1:0] rd_word;

    // s_ready ignores a same-cycle pop, so a full buffer always refuses a push
    assign s_ready      = level_q < (AW+1)'(DEPTH);
    assign push         = s_valid && s_ready && !flush;
    assign app_wdf_wren = (level_q != '0) && !flush;
    assign pop          = app_wdf_wren && app_wdf_rdy;

    assign app_wdf_end  = (BPB == 1) ? (phase_q == BEAT0) : (phase_q == BEAT1);
    assign level        = level_q;
    assign burst_done   = burst_done_q;

    assign {app_wdf_mask, app_wdf_data} = rd_word;

    mpmc11_wdf_ram #(
        .W     (DW + MW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({s_mask, s_data}),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level_q      <= '0;
            burst_done_q <= 1'b0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level_q      <= '0;
            burst_done_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
            burst_done_q <= pop && app_wdf_end;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= BEAT0;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (flush) begin
            phase_d = BEAT0;
        end else if (pop && (BPB == 2)) begin
            phase_d = (phase_q == BEAT0) ? BEAT1 : BEAT0;
        end
    end

endmodule

// File: tb/tb_mpmc11_wdf_feeder.sv
// Scoreboard bench: one feeder in 4:1 mode (BPB=1) and one in 2:1 mode (BPB=2).
module tb_mpmc11_wdf_feeder;

    localparam int unsigned DW = 128;
    localparam int unsigned MW = DW / 8;
    localparam int unsigned CW = DW + MW;

    typedef struct packed {
        logic [MW-1:0] m;
        logic [DW-1:0] d;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush       [2];
    logic          s_valid     [2];
    logic          s_ready     [2];
    logic [DW-1:0] s_data      [2];
    logic [MW-1:0] s_mask      [2];
    logic          app_wdf_rdy [2];
    logic          wren        [2];
    logic [DW-1:0] wdata       [2];
    logic [MW-1:0] wmask       [2];
    logic          wend        [2];
    logic [2:0]    level       [2];
    logic          bdone       [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int unsigned BPB_G = g + 1;

        mpmc11_wdf_feeder #(
            .DW    (DW),
            .DEPTH (4),
            .BPB   (BPB_G)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .flush        (flush[g]),
            .s_valid      (s_valid[g]),
            .s_ready      (s_ready[g]),
            .s_data       (s_data[g]),
            .s_mask       (s_mask[g]),
            .app_wdf_rdy  (app_wdf_rdy[g]),
            .app_wdf_wren (wren[g]),
            .app_wdf_data (wdata[g]),
            .app_wdf_mask (wmask[g]),
            .app_wdf_end  (wend[g]),
            .level        (level[g]),
            .burst_done   (bdone[g])
        );

        beat_t q[$];
        beat_t e;
        logic  ph;
        logic  pend;
        logic  np;
        logic  exp_end;
        logic  m_wren;
        logic  m_ready;
        int    bd_cnt = 0;

        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                ph   = 1'b0;
                pend = 1'b0;
            end else begin
                m_wren  = (q.size() != 0) && !flush[g];
                m_ready = q.size() < 4;
                if (bdone[g]) bd_cnt++;
                chk($sformatf("i%0d_burst_done", g), bdone[g], pend);
                chk($sformatf("i%0d_level", g), level[g], q.size());
                chk($sformatf("i%0d_wren", g), wren[g], m_wren);
                chk($sformatf("i%0d_s_ready", g), s_ready[g], m_ready);
                if (flush[g]) begin
                    q.delete();
                    ph   = 1'b0;
                    pend = 1'b0;
                end else begin
                    np = 1'b0;
                    if (m_wren && app_wdf_rdy[g]) begin
                        e       = q.pop_front();
                        exp_end = (BPB_G == 1) ? 1'b1 : ph;
                        chk($sformatf("i%0d_data", g), wdata[g], e.d);
                        chk($sformatf("i%0d_mask", g), wmask[g], e.m);
                        chk($sformatf("i%0d_end", g), wend[g], exp_end);
                        np = exp_end;
                        if (BPB_G == 2) ph = ~ph;
                    end
                    if (s_valid[g] && m_ready) begin
                        q.push_back({s_mask[g], s_data[g]});
                    end
                    pend = np;
                end
            end
        end
    end

    task automatic send(input int i, input logic [DW-1:0] d, input logic [MW-1:0] m);
        bit ok;
        ok = 1'b0;
        @(posedge clk) #1;
        s_valid[i] = 1'b1;
        s_data[i]  = d;
        s_mask[i]  = m;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (s_ready[i]) ok = 1'b1;
        end
        chk("send_accept", ok, 1'b1);
        @(posedge clk) #1;
        s_valid[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (level[i] == 3'd0) done = 1'b1;
        end
        chk("drain", done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            flush[i]       = 1'b0;
            s_valid[i]     = 1'b0;
            s_data[i]      = '0;
            s_mask[i]      = '0;
            app_wdf_rdy[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_level", level[i], 3'd0);
            chk("rst_wren", wren[i], 1'b0);
            chk("rst_s_ready", s_ready[i], 1'b1);
            chk("rst_burst_done", bdone[i], 1'b0);
            chk("rst_end", wend[i], (i == 0));
        end
        @(posedge clk) #1;
        rst_n = 1'b1;

        // single beat, 4:1 mode
        app_wdf_rdy[0] = 1'b1;
        send(0, {16{8'hA5}}, '0);
        @(negedge clk);
        chk("one_wren", wren[0], 1'b1);
        chk("one_end", wend[0], 1'b1);
        chk("one_data", wdata[0], {16{8'hA5}});
        @(negedge clk);
        chk("one_done_pulse", bdone[0], 1'b1);
        @(negedge clk);
        chk("one_done_clear", bdone[0], 1'b0);

        // fill with MIG stalled, then full push+pop collision
        app_wdf_rdy[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(0, {4{32'h1000_0000 + 32'(k)}}, MW'(16'h0101 << k));
        end
        @(posedge clk) #1;
        s_valid[0] = 1'b1;
        s_data[0]  = {4{32'hCAFE_0005}};
        s_mask[0]  = 16'hF00F;
        repeat (2) @(negedge clk);
        chk("full_s_ready", s_ready[0], 1'b0);
        chk("full_level", level[0], 3'd4);
        @(posedge clk) #1;
        app_wdf_rdy[0] = 1'b1;
        @(negedge clk);
        chk("full_level_pre", level[0], 3'd4);
        @(negedge clk);
        chk("full_collide_level", level[0], 3'd3);
        @(posedge clk) #1;
        s_valid[0] = 1'b0;
        drain(0);

        // 2:1 mode, two bursts
        base = gi[1].bd_cnt;
        app_wdf_rdy[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(1, {4{32'h2000_0000 + 32'(k)}}, MW'(k));
        end
        drain(1);
        repeat (2) @(negedge clk);
        chk("bpb2_burst_count", gi[1].bd_cnt - base, 2);

        // flush mid-burst
        send(1, {4{32'h3000_000A}}, '0);
        repeat (2) @(negedge clk);
        app_wdf_rdy[1] = 1'b0;
        send(1, {4{32'h3000_000B}}, '0);
        @(posedge clk) #1;
        flush[1] = 1'b1;
        @(negedge clk);
        chk("flush_wren_during", wren[1], 1'b0);
        @(posedge clk) #1;
        flush[1] = 1'b0;
        @(negedge clk);
        chk("flush_level", level[1], 3'd0);
        chk("flush_wren", wren[1], 1'b0);
        app_wdf_rdy[1] = 1'b1;
        send(1, {4{32'h3000_000C}}, 16'h00FF);
        @(negedge clk);
        chk("flush_next_wren", wren[1], 1'b1);
        chk("flush_next_end", wend[1], 1'b0);
        drain(1);

        // asynchronous reset with beats buffered
        app_wdf_rdy[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send(0, {4{32'h4000_0000 + 32'(k)}}, '0);
        end
        @(negedge clk);
        chk("pre_rst_level", level[0], 3'd3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", level[0], 3'd0);
        chk("arst_wren", wren[0], 1'b0);
        chk("arst_s_ready", s_ready[0], 1'b1);
        chk("arst_end", wend[0], 1'b1);
        chk("arst_burst_done", bdone[0], 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk) #1;
        rst_n = 1'b1;
        app_wdf_rdy[0] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("post_rst_wren", wren[0], 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
